// File: rtl/rect_pixel_writer.sv
// Converts a linear pixel-index stream into clipped screen coordinates for a
// filled rectangle and drives the VGA plot strobe through a two-stage pipeline.
module rect_pixel_writer #(
    parameter int IDX_W = 17,
    parameter int X_W   = 9,
    parameter int Y_W   = 8,
    parameter int COL_W = 3,
    parameter int SCR_W = 320,
    parameter int SCR_H = 240
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [X_W-1:0]   rect_x,
    input  logic [Y_W-1:0]   rect_y,
    input  logic [X_W-1:0]   rect_w,
    input  logic [Y_W-1:0]   rect_h,
    input  logic [COL_W-1:0] colour,
    input  logic [IDX_W-1:0] idx,
    input  logic             idx_finished,
    output logic [IDX_W-1:0] limit,
    output logic [X_W-1:0]   vga_x,
    output logic [Y_W-1:0]   vga_y,
    output logic [COL_W-1:0] vga_colour,
    output logic             vga_plot,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {IDLE, RUN, DRAIN, EMPTY, DONE} state_t;

    localparam logic [X_W:0] SCR_W_L = (X_W+1)'(SCR_W);
    localparam logic [Y_W:0] SCR_H_L = (Y_W+1)'(SCR_H);

    state_t           state;
    logic [X_W-1:0]   lat_x;
    logic [X_W-1:0]   lat_w;
    logic [Y_W-1:0]   lat_y;
    logic [Y_W-1:0]   lat_h;
    logic [COL_W-1:0] lat_colour;
    logic [X_W-1:0]   col;
    logic [Y_W-1:0]   row;
    logic [IDX_W-1:0] exp_idx;
    logic             s1_valid;
    logic [X_W-1:0]   s1_col;
    logic [Y_W-1:0]   s1_row;

    logic             accept;
    logic [IDX_W-1:0] exp_next;
    logic [X_W:0]     pix_x;
    logic [Y_W:0]     pix_y;

    // Only the index we are waiting for is taken; duplicates and gaps are dropped.
    assign accept   = (state == RUN) && !idx_finished && (idx == exp_idx);
    assign exp_next = exp_idx + IDX_W'(1);
    assign pix_x    = {1'b0, lat_x} + {1'b0, s1_col};
    assign pix_y    = {1'b0, lat_y} + {1'b0, s1_row};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            lat_x      <= '0;
            lat_w      <= '0;
            lat_y      <= '0;
            lat_h      <= '0;
            lat_colour <= '0;
            col        <= '0;
            row        <= '0;
            exp_idx    <= '0;
            s1_valid   <= 1'b0;
            s1_col     <= '0;
            s1_row     <= '0;
            limit      <= '0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_col <= col;
                s1_row <= row;
            end

            // Clipped pixels flow through the pipe but never raise the strobe.
            vga_plot <= s1_valid && (pix_x < SCR_W_L) && (pix_y < SCR_H_L);
            if (s1_valid) begin
                vga_x      <= pix_x[X_W-1:0];
                vga_y      <= pix_y[Y_W-1:0];
                vga_colour <= lat_colour;
            end

            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        lat_x      <= rect_x;
                        lat_y      <= rect_y;
                        lat_w      <= rect_w;
                        lat_h      <= rect_h;
                        lat_colour <= colour;
                        limit      <= {{(IDX_W-X_W){1'b0}}, rect_w} *
                                      {{(IDX_W-Y_W){1'b0}}, rect_h};
                        col        <= '0;
                        row        <= '0;
                        exp_idx    <= '0;
                        busy       <= 1'b1;
                        state      <= (rect_w == '0 || rect_h == '0) ? EMPTY : RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        exp_idx <= exp_next;
                        if (col == lat_w - X_W'(1)) begin
                            col <= '0;
                            row <= row + Y_W'(1);
                        end else begin
                            col <= col + X_W'(1);
                        end
                        if (exp_next == limit) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Stage 1 empty now means stage 2 is empty after this edge.
                    if (!s1_valid) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                EMPTY: begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rect_pixel_writer.sv
// Randomised scoreboard bench for rect_pixel_writer: the stimulus side pushes
// expected plots from a row-major rectangle model, a monitor pops and compares.
module tb_rect_pixel_writer;

    localparam int IDX_W = 17;
    localparam int X_W   = 9;
    localparam int Y_W   = 8;
    localparam int COL_W = 3;

    logic             clk;
    logic             resetn;
    logic             start;
    logic [X_W-1:0]   rect_x;
    logic [Y_W-1:0]   rect_y;
    logic [X_W-1:0]   rect_w;
    logic [Y_W-1:0]   rect_h;
    logic [COL_W-1:0] colour;
    logic [IDX_W-1:0] idx;
    logic             idx_finished;
    logic [IDX_W-1:0] limit;
    logic [X_W-1:0]   vga_x;
    logic [Y_W-1:0]   vga_y;
    logic [COL_W-1:0] vga_colour;
    logic             vga_plot;
    logic             busy;
    logic             done;

    rect_pixel_writer dut (
        .clk(clk), .resetn(resetn), .start(start),
        .rect_x(rect_x), .rect_y(rect_y), .rect_w(rect_w), .rect_h(rect_h),
        .colour(colour), .idx(idx), .idx_finished(idx_finished),
        .limit(limit), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
        .vga_plot(vga_plot), .busy(busy), .done(done)
    );

    typedef struct {
        int x;
        int y;
        int c;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string name, input longint act, input longint expv);
        checks++;
        if (act == expv) passes++;
        else $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every strobe must match the oldest outstanding expected pixel.
    always @(negedge clk) begin
        if (resetn && vga_plot) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("[TB] FAIL unexpected_plot: got (%0d,%0d) expected no plot", vga_x, vga_y);
            end else begin
                mon_e = exp_q.pop_front();
                check_val("plot_x", longint'(vga_x), longint'(mon_e.x));
                check_val("plot_y", longint'(vga_y), longint'(mon_e.y));
                check_val("plot_colour", longint'(vga_colour), longint'(mon_e.c));
                check_val("plot_cycle", longint'(cyc), longint'(mon_e.cyc));
            end
        end
    end

    task automatic drive_rect(input int rx, input int ry, input int rw, input int rh, input int rc);
        rect_x = X_W'(rx);
        rect_y = Y_W'(ry);
        rect_w = X_W'(rw);
        rect_h = Y_W'(rh);
        colour = COL_W'(rc);
    endtask

    // Reference: pixel i of a w-wide rectangle is at (rx + i%w, ry + i/w).
    task automatic push_expected(input int rx, input int ry, input int rw, input int rc, input int i);
        exp_t e;
        e.x   = rx + (i % rw);
        e.y   = ry + (i / rw);
        e.c   = rc;
        e.cyc = cyc + 2;
        if (e.x < 320 && e.y < 240) exp_q.push_back(e);
    endtask

    task automatic run_rect(input int rx, input int ry, input int rw, input int rh, input int rc,
                            input int stall_pct, input int dup_at, input bit inject);
        int  n;
        int  i;
        int  last_cyc;
        int  done_cyc;
        bit  found;
        n = rw * rh;
        start = 1'b1;
        drive_rect(rx, ry, rw, rh, rc);
        idx = '0;
        idx_finished = 1'b1;
        step();
        start = 1'b0;
        drive_rect(int'($urandom_range(0, 511)), int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 511)), int'($urandom_range(0, 255)), int'($urandom_range(0, 7)));
        check_val("limit_after_start", longint'(limit), longint'(n));
        check_val("busy_after_start", longint'(busy), 1);
        if (n == 0) begin
            check_val("empty_plot", longint'(vga_plot), 0);
            step();
            check_val("empty_done", longint'(done), 1);
            check_val("empty_busy_low", longint'(busy), 0);
            step();
            check_val("empty_done_once", longint'(done), 0);
            return;
        end
        i = 0;
        last_cyc = cyc;
        while (i < n) begin
            if (i == dup_at + 1) begin
                repeat (2) begin
                    idx = IDX_W'(dup_at);
                    idx_finished = 1'b0;
                    step();
                end
            end
            if (int'($urandom_range(0, 99)) < stall_pct) begin
                if (i > 0 && $urandom_range(0, 1) == 1) begin
                    idx = IDX_W'(i - 1);
                    idx_finished = 1'b0;
                end else begin
                    idx = IDX_W'(i);
                    idx_finished = 1'b1;
                end
                step();
            end else begin
                idx = IDX_W'(i);
                idx_finished = 1'b0;
                push_expected(rx, ry, rw, rc, i);
                last_cyc = cyc;
                if (inject && i == n / 2) begin
                    start = 1'b1;
                    drive_rect(1, 2, 7, 7, (rc + 1) % 8);
                end
                step();
                start = 1'b0;
                i++;
            end
        end
        idx_finished = 1'b1;
        found = 1'b0;
        done_cyc = 0;
        for (int k = 0; k < 16 && !found; k++) begin
            if (done) begin
                found = 1'b1;
                done_cyc = cyc;
            end else begin
                step();
            end
        end
        check_val("done_seen", longint'(found), 1);
        check_val("done_cycle", longint'(done_cyc), longint'(last_cyc + 3));
        check_val("busy_at_done", longint'(busy), 0);
        check_val("limit_held", longint'(limit), longint'(n));
        check_val("plots_outstanding", longint'(exp_q.size()), 0);
        exp_q.delete();
        step();
        check_val("done_once", longint'(done), 0);
        step();
    endtask

    task automatic reset_mid_run();
        int pulses;
        start = 1'b1;
        drive_rect(40, 50, 8, 8, 6);
        idx_finished = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            idx = IDX_W'(i);
            idx_finished = 1'b0;
            push_expected(40, 50, 8, 6, i);
            step();
        end
        #2;
        resetn = 1'b0;
        #1;
        check_val("rst_busy", longint'(busy), 0);
        check_val("rst_plot", longint'(vga_plot), 0);
        check_val("rst_xy", longint'({vga_x, vga_y, vga_colour}), 0);
        check_val("rst_limit", longint'(limit), 0);
        exp_q.delete();
        idx_finished = 1'b1;
        step();
        step();
        resetn = 1'b1;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (done || vga_plot) pulses++;
        end
        check_val("rst_no_done", longint'(pulses), 0);
    endtask

    initial begin
        resetn = 1'b0;
        start = 1'b0;
        drive_rect(0, 0, 0, 0, 0);
        idx = '0;
        idx_finished = 1'b1;
        #3;
        check_val("reset_busy", longint'(busy), 0);
        check_val("reset_done", longint'(done), 0);
        check_val("reset_plot", longint'(vga_plot), 0);
        check_val("reset_limit", longint'(limit), 0);
        step();
        step();
        resetn = 1'b1;
        step();

        run_rect(10, 20, 3, 2, 5, 0, -10, 1'b0);
        run_rect(318, 239, 4, 1, 3, 0, -10, 1'b0);
        run_rect(5, 5, 0, 7, 2, 0, -10, 1'b0);
        run_rect(100, 100, 4, 2, 1, 0, 2, 1'b0);
        run_rect(30, 40, 4, 3, 4, 0, -10, 1'b1);
        reset_mid_run();
        run_rect(10, 20, 3, 2, 5, 0, -10, 1'b0);
        for (int t = 0; t < 8; t++) begin
            run_rect(int'($urandom_range(0, 330)), int'($urandom_range(0, 250)),
                     int'($urandom_range(1, 10)), int'($urandom_range(1, 5)),
                     int'($urandom_range(0, 7)), 25, -10, 1'b0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/rect_pixel_writer.md
# rect_pixel_writer

Downstream consumer of the rendering index counter. Turns the counter's linear index stream into screen coordinates for a filled rectangle and drives the VGA adapter plot interface. It also supplies the counter's `limit` (width × height). It latches the rectangle on `start`, walks the rectangle row-major, clips off-screen pixels, and pulses `done` once the last pixel has been issued.

## Interface
Parameters:
- `IDX_W`, 17: index/limit width; equals `X_Y_PRODUCT_BITES`.
- `X_W`, 9: x coordinate width.
- `Y_W`, 8: y coordinate width.
- `COL_W`, 3: colour width.
- `SCR_W`, 320: screen width; x ≥ SCR_W is clipped.
- `SCR_H`, 240: screen height; y ≥ SCR_H is clipped.

Ports:
- `clk`  in  1: clock; all state changes on the rising edge.
- `resetn`  in  1: asynchronous, active-low reset.
- `start`  in  1: one-cycle request; also drives the counter's `start_count`.
- `rect_x`  in  X_W: left edge, sampled on accepted `start`.
- `rect_y`  in  Y_W: top edge, sampled on accepted `start`.
- `rect_w`  in  X_W: width, sampled on accepted `start`.
- `rect_h`  in  Y_W: height, sampled on accepted `start`.
- `colour`  in  COL_W: fill colour, sampled on accepted `start`.
- `idx`  in  IDX_W: counter `result`.
- `idx_finished`  in  1: counter `has_finished`.
- `limit`  out  IDX_W: registered rect_w × rect_h, fed to the counter.
- `vga_x`  out  X_W: pixel x.
- `vga_y`  out  Y_W: pixel y.
- `vga_colour`  out  COL_W: pixel colour.
- `vga_plot`  out  1: write strobe; `vga_x`, `vga_y`, `vga_colour` are valid only when high.
- `busy`  out  1: high from the cycle after an accepted `start` until `done`.
- `done`  out  1: one-cycle completion pulse.

## Operation
- States:
  - IDLE: `start` is accepted only here. On acceptance, latch rect_x/y/w/h and colour, set `limit` = rect_w × rect_h (full 17-bit product, no truncation), clear col/row/exp to 0.
    - Next state is EMPTY if rect_w == 0 or rect_h == 0, otherwise RUN.
  - RUN: stage-0 accept happens when `idx_finished == 0` and `idx == exp`. On accept:
    - Push (col, row) into stage 1 and increment exp.
    - If col == rect_w−1, set col = 0 and row = row+1; otherwise col = col+1.
    - A mismatched idx (duplicate or skipped value) is not accepted and is dropped silently. A skipped value stalls the walk until `start` is re-issued after reset.
    - When exp reaches `limit` after an accept, go to DRAIN.
  - DRAIN: wait until stages 1 and 2 are empty, then go to DONE.
  - EMPTY: issues no plots; goes to DONE next cycle.
  - DONE: `done` = 1 for exactly one cycle, `busy` = 0, return to IDLE.
- Pipeline:
  - Stage 1 registers the valid bit, col and row.
  - Stage 2 computes x = rect_x + col (X_W+1 bits) and y = rect_y + row (Y_W+1 bits).
  - `vga_plot` = valid & (x < SCR_W) & (y < SCR_H).
  - `vga_x` and `vga_y` carry the low X_W / Y_W bits.
- Clipped pixels still consume an index and still count toward completion.
- `start` outside IDLE is ignored; latched parameters and `limit` are unchanged.
- Inputs rect_* and colour are don't-care except in the `start` cycle.

## Timing
- Reset (async assert, sync release): state IDLE.
  - `busy`, `done`, `vga_plot` = 0.
  - `vga_x`, `vga_y`, `vga_colour`, `limit` = 0.
  - Pipeline valids, col, row and exp = 0.
- Reset mid-RUN aborts immediately: no `done`, and any in-flight plot is dropped.
- Start latency:
  - `limit` is valid on the cycle after `start`.
  - `busy` rises on the cycle after `start`.
- Accept-to-plot latency is exactly 2 cycles. A stage-0 accept at cycle n produces `vga_plot` at n+2.
- With one idx advance per cycle, throughput is 1 pixel/cycle with no bubbles.
- `done` occurs 1 cycle after the last stage-2 valid; total cycles from first accept to `done` = N + 2.
- EMPTY rectangle: `busy` is high 1 cycle, and `done` fires 2 cycles after `start`.
- Colour is constant for the whole rectangle.

## Test plan
- Reset mid-run: reset asserted during RUN of an 8×8 rectangle → all outputs 0 asynchronously, `done` never pulses, next `start` works normally.
- Basic 3×2 rectangle at (10,20), colour 5, counter emitting 0..5 → `limit` = 6.
  - Plots, in order: (10,20) (11,20) (12,20) (10,21) (11,21) (12,21), all colour 5.
  - First plot arrives 2 cycles after idx 0 is accepted; `done` arrives 1 cycle after the last plot.
- Clipping: w=4, h=1 at (318,239) → only (318,239) and (319,239) are plotted; `done` still follows 4 accepts.
- Zero size: w=0, h=7 → `limit` = 0, no `vga_plot`, `done` 2 cycles after `start`.
- Duplicate index: counter holds idx=2 for 3 cycles → exactly one plot for index 2, ordering preserved, total plots = w×h.
- Start while busy: second `start` with different rect mid-run → ignored; first rect completes unchanged; `limit` unchanged.
